// File: rtl/xor_nn_backprop_if.sv
// xor_nn_backprop_if: bundle between a host and the xor_nn_backprop training engine.
// Ports: start/x/y/a2_0..a2_2/a3 request one step with its sample and forward-pass
// activations; wr_en/wr_addr/wr_data load a weight; rd_addr/rd_data read one back;
// busy/done report step progress.
interface xor_nn_backprop_if;
    logic              start;
    logic [1:0]        x;
    logic              y;
    logic [7:0]        a2_0, a2_1, a2_2, a3;
    logic              wr_en;
    logic [3:0]        wr_addr;
    logic signed [7:0] wr_data;
    logic [3:0]        rd_addr;
    logic signed [7:0] rd_data;
    logic              busy, done;
    modport master (output start, x, y, a2_0, a2_1, a2_2, a3, wr_en, wr_addr, wr_data, rd_addr,
                    input rd_data, busy, done);
    modport slave (input start, x, y, a2_0, a2_1, a2_2, a3, wr_en, wr_addr, wr_data, rd_addr,
                   output rd_data, busy, done);
endinterface

// File: rtl/xor_nn_backprop.sv
// xor_nn_backprop: one backpropagation step for a 2-3-1 sigmoid network with Q0.7 activations.
// Ports: clock, reset_n (async, active low), bus (slave side of xor_nn_backprop_if).
// Weight file address map: 2j+i = W1[j][i], 6-8 = W2[j], 9-11 = B1[j], 12 = B2, 13-15 read 0.
module xor_nn_backprop #(
    parameter int LR_SHIFT = 3
) (
    input logic              clock,
    input logic              reset_n,
    xor_nn_backprop_if.slave bus
);
    typedef enum logic [2:0] {IDLE, DELTA3, DELTA2, UPD_OUT, UPD_HID, DONE} state_t;
    localparam logic signed [7:0] W_INIT [16] = '{8'sd47, -8'sd61, -8'sd35, -8'sd46, 8'sd55, -8'sd37,
        8'sd75, -8'sd44, -8'sd66, -8'sd23, 8'sd7, 8'sd13, 8'sd33, 8'sd0, 8'sd0, 8'sd0};
    state_t            r_state, w_next;
    logic [1:0]        r_cnt;
    logic signed [7:0] r_w [16];
    logic [1:0]        r_x;
    logic              r_y;
    logic [7:0]        r_a2 [3];
    logic [7:0]        r_a3;
    logic signed [7:0] r_d3;
    logic signed [7:0] r_d2 [3];
    logic signed [31:0] w_e3, w_d3, w_w2, w_d2, w_odelta, w_hdelta;
    logic [3:0]        w_oaddr, w_h0, w_h1, w_hb;

    function automatic logic signed [7:0] sat8(input logic signed [31:0] v);
        return v > 32'sd127 ? 8'sd127 : v < -32'sd128 ? 8'sh80 : $signed(v[7:0]);
    endfunction

    // Sigmoid derivative a*(1-a) in Q0.7.
    function automatic logic signed [31:0] dsig(input logic [7:0] a);
        logic signed [31:0] v;
        v = $signed(32'(a));
        return (v * (32'sd128 - v)) >>> 7;
    endfunction

    always_comb begin
        w_e3 = $signed(32'(r_a3)) - (r_y ? 32'sd127 : 32'sd0);
        w_d3 = (w_e3 * dsig(r_a3)) >>> 7;
        w_w2 = 32'(r_w[4'd6 + 4'(r_cnt)]);
        w_d2 = (((w_w2 * 32'(r_d3)) >>> 7) * dsig(r_a2[r_cnt])) >>> 7;
        // The fourth UPD_OUT cycle updates the output bias instead of a W2 entry.
        w_oaddr = r_cnt == 2'd3 ? 4'd12 : 4'd6 + 4'(r_cnt);
        w_odelta = r_cnt == 2'd3 ? 32'(r_d3) >>> LR_SHIFT
                                 : (32'(r_d3) * $signed(32'(r_a2[r_cnt]))) >>> (7 + LR_SHIFT);
        w_h0 = {1'b0, r_cnt, 1'b0};
        w_h1 = {1'b0, r_cnt, 1'b1};
        w_hb = 4'd9 + 4'(r_cnt);
        w_hdelta = 32'(r_d2[r_cnt]) >>> LR_SHIFT;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_next != r_state ? 2'd0 : r_cnt + 2'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? DELTA3 : IDLE;
            DELTA3:  w_next = DELTA2;
            DELTA2:  w_next = r_cnt == 2'd2 ? UPD_OUT : DELTA2;
            UPD_OUT: w_next = r_cnt == 2'd3 ? UPD_HID : UPD_OUT;
            UPD_HID: w_next = r_cnt == 2'd2 ? DONE : UPD_HID;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = r_state != IDLE;
        bus.done    = r_state == DONE;
        bus.rd_data = r_w[bus.rd_addr];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_w  <= W_INIT;
            r_d3 <= '0;
            r_d2 <= '{default: '0};
            r_x  <= '0;
            r_y  <= 1'b0;
            r_a2 <= '{default: '0};
            r_a3 <= '0;
        end else begin
            if (r_state == IDLE) begin
                if (bus.wr_en && bus.wr_addr < 4'd13) r_w[bus.wr_addr] <= bus.wr_data;
                if (bus.start) begin
                    r_x     <= bus.x;
                    r_y     <= bus.y;
                    r_a2[0] <= bus.a2_0;
                    r_a2[1] <= bus.a2_1;
                    r_a2[2] <= bus.a2_2;
                    r_a3    <= bus.a3;
                end
            end
            if (r_state == DELTA3) r_d3 <= sat8(w_d3);
            if (r_state == DELTA2) r_d2[r_cnt] <= sat8(w_d2);
            if (r_state == UPD_OUT) r_w[w_oaddr] <= sat8(32'(r_w[w_oaddr]) - w_odelta);
            if (r_state == UPD_HID) begin
                if (r_x[0]) r_w[w_h0] <= sat8(32'(r_w[w_h0]) - w_hdelta);
                if (r_x[1]) r_w[w_h1] <= sat8(32'(r_w[w_h1]) - w_hdelta);
                r_w[w_hb] <= sat8(32'(r_w[w_hb]) - w_hdelta);
            end
        end
    end
endmodule

// File: doc/xor_nn_backprop.md
XOR_NN_BACKPROP -- requirements
Module: xor_nn_backprop

Interface
REQ-001 SHALL have parameter: LR_SHIFT, 3, learning-rate right-shift applied to every weight/bias gradient.
REQ-002 SHALL have port: clock  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request one training step; sampled only in IDLE.
REQ-005 SHALL have port: x  input  2  sample features; x[0] pairs with W1[j][0], x[1] with W1[j][1].
REQ-006 SHALL have port: y  input  1  target label; 1 -> target 127, 0 -> target 0.
REQ-007 SHALL have ports: a2_0, a2_1, a2_2  input  8 each  hidden sigmoid outputs from the forward pass, unsigned Q0.7.
REQ-008 SHALL have port: a3  input  8  output sigmoid from the forward pass, unsigned Q0.7.
REQ-009 SHALL have ports: wr_en input 1, wr_addr input 4, wr_data input 8 (signed)  host weight load.
REQ-010 SHALL have ports: rd_addr input 4, rd_data output 8 (signed)  combinational weight readback.
REQ-011 SHALL have ports: busy output 1, done output 1  status.

Function
REQ-012 SHALL use the address map: 2j+i = W1[j][i] (0-5), 6-8 = W2[0..2], 9-11 = B1[0..2], 12 = B2; addresses 13-15 read 0 and ignore writes.
REQ-013 SHALL latch x, y, a2_*, a3 on the rising edge where start=1 in IDLE (edge E0), then move to DELTA3.
REQ-014 SHALL sequence states IDLE -> DELTA3 (1 cycle) -> DELTA2 (3 cycles, j=0..2) -> UPD_OUT (4 cycles: W2[0], W2[1], W2[2], B2) -> UPD_HID (3 cycles, j=0..2) -> DONE (1 cycle) -> IDLE.
REQ-015 SHALL assert done for exactly one cycle, in the cycle after edge E0+11; busy SHALL be high whenever state != IDLE.
REQ-016 SHALL ignore start and wr_en while busy; wr_en in IDLE writes wr_data to wr_addr on that edge; start and wr_en on the same IDLE edge: the write lands, then the step begins.
REQ-017 SHALL compute in DELTA3: e3 = a3 - t (9-bit signed); s3 = (a3*(128-a3))>>>7; d3 = sat8((e3*s3)>>>7).
REQ-018 SHALL compute in DELTA2, using the pre-update W2[j]: d2[j] = sat8((((W2[j]*d3)>>>7) * s2j)>>>7), where s2j = (a2_j*(128-a2_j))>>>7.
REQ-019 SHALL update in UPD_OUT: W2[j] <= sat8(W2[j] - ((d3*a2_j)>>>(7+LR_SHIFT))); B2 <= sat8(B2 - (d3>>>LR_SHIFT)).
REQ-020 SHALL update in UPD_HID j: W1[j][i] <= sat8(W1[j][i] - (d2[j]>>>LR_SHIFT)) if x[i]=1, else unchanged; B1[j] <= sat8(B1[j] - (d2[j]>>>LR_SHIFT)).
REQ-021 SHALL use >>> as an arithmetic, floor-rounding shift, all intermediates at least 17-bit signed; sat8 clamps to [-128, 127].

Reset
REQ-022 SHALL, on reset_n low at any time, including mid-step, asynchronously force state IDLE, busy=0, done=0, and d3/d2 to 0.
REQ-023 SHALL reload weights on reset: W1 = {47,-61},{-35,-46},{55,-37}; W2 = {75,-44,-66}; B1 = {-23,7,13}; B2 = 33.

Verification
REQ-024 SHALL pass: after reset, x=00, y=0, a2_*=64, a3=64, start pulse -> d3=16, d2={2,-2,-3}; W2={74,-45,-67}, B2=31, B1={-23,8,14}, W1 unchanged; done is seen 11 edges after start.
REQ-025 SHALL pass: same stimulus with x=11 -> W1 = {47,-61},{-34,-45},{56,-36}; all other results as in REQ-024.
REQ-026 SHALL pass: x=11, y=1, a3=127, any a2 -> d3=0; all 13 weights unchanged; done still pulses once.
REQ-027 SHALL pass: write W2[0]=-128 (addr 6), then the REQ-024 stimulus -> W2[0] saturates at -128; rd_addr=6 returns 0x80.
REQ-028 SHALL pass: start pulse, second start and wr_en at E0+3 -> both ignored, exactly one done; reset_n low at E0+6 -> busy=0 immediately, weights equal REQ-023 values.
